// File: rtl/gf2m_mul_serial.sv
// Digit-serial GF(2^M) multiplier: D bits of b per cycle, MSB digit first.
// Produces either a*b mod POLY or the raw (2M-1)-bit carry-less product.
module gf2m_mul_serial #(
  parameter int         M    = 8,
  parameter int         D    = 2,
  parameter logic [M:0] POLY = 9'h11B
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [M-1:0]   a,
  input  logic [M-1:0]   b,
  input  logic           raw,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*M-2:0] c,
  output logic           busy
);

  localparam int N  = (M + D - 1) / D;
  localparam int NB = N * D;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = 2 * M - 1;
  localparam int AW = M + D;
  localparam int PW = M + D - 1;
  localparam logic [AW-1:0] POLY_W = AW'(POLY);

  if (POLY[M] != 1'b1) begin : g_bad_poly
    $error("gf2m_mul_serial: POLY bit M must be 1");
  end
  if (M < 2 || M > 64) begin : g_bad_m
    $error("gf2m_mul_serial: M out of range 2..64");
  end
  if (D < 1 || D > M) begin : g_bad_d
    $error("gf2m_mul_serial: D out of range 1..M");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [M-1:0]    a_q;
  logic [NB-1:0]   b_q;
  logic            raw_q;
  logic [CW-1:0]   acc, acc_nxt;
  logic [KW-1:0]   k;
  logic [D-1:0]    digit;
  logic [PW-1:0]   prod;

  function automatic logic [PW-1:0] clmul(input logic [M-1:0] x, input logic [D-1:0] y);
    logic [PW-1:0] r;
    r = '0;
    for (int j = 0; j < D; j++)
      if (y[j]) r = r ^ (PW'(x) << j);
    return r;
  endfunction

  // Clear the D overflow bits from the top down; each fold can only touch lower bits.
  function automatic logic [M-1:0] fold(input logic [AW-1:0] t);
    logic [AW-1:0] r;
    r = t;
    for (int i = AW - 1; i >= M; i--)
      if (r[i]) r = r ^ (POLY_W << (i - M));
    return r[M-1:0];
  endfunction

  always_comb begin
    digit   = D'(b_q >> (int'(k) * D));
    prod    = clmul(a_q, digit);
    acc_nxt = raw_q ? ((acc << D) ^ CW'(prod))
                    : CW'(fold((AW'(acc[M-1:0]) << D) ^ AW'(prod)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (k == '0) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      raw_q <= 1'b0;
      acc   <= '0;
      k     <= '0;
      c     <= '0;
    end else if (!clear) begin
      case (state)
        IDLE: if (in_valid) begin
          a_q   <= a;
          b_q   <= NB'(b);
          raw_q <= raw;
          acc   <= '0;
          k     <= KW'(N - 1);
        end
        BUSY: begin
          acc <= acc_nxt;
          k   <= k - 1'b1;
          if (k == '0) c <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf2m_mul_serial.sv
// Bench for gf2m_mul_serial: six configurations share stimulus, a per-instance
// expected-result queue is filled at acceptance and drained on each output handshake.
module tb_gf2m_mul_serial;

  logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1, raw_s = 1'b0;
  logic [15:0] a_s = '0, b_s = '0;
  logic [5:0]  in_ready_v, out_valid_v, busy_v;
  logic [14:0] c8 [5];
  logic [30:0] c16;

  int          n_pass = 0, n_total = 0, edges = 0;
  int          lat  [6];
  bit          seen [6];
  logic [30:0] exp_q [6][$];
  int          n_v  [6] = '{4, 3, 8, 2, 1, 4};
  int          m_v  [6] = '{8, 8, 8, 8, 8, 16};
  logic [16:0] p_v  [6] = '{17'h11B, 17'h11B, 17'h11B, 17'h11B, 17'h11B, 17'h1002B};

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        raw;
    logic [14:0] exp;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  gf2m_mul_serial #(.M(8), .D(2), .POLY(9'h11B)) u0 (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_v[0]), .a(a_s[7:0]), .b(b_s[7:0]), .raw(raw_s),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .c(c8[0]), .busy(busy_v[0]));
  gf2m_mul_serial #(.M(8), .D(3), .POLY(9'h11B)) u1 (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_v[1]), .a(a_s[7:0]), .b(b_s[7:0]), .raw(raw_s),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .c(c8[1]), .busy(busy_v[1]));
  gf2m_mul_serial #(.M(8), .D(1), .POLY(9'h11B)) u2 (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_v[2]), .a(a_s[7:0]), .b(b_s[7:0]), .raw(raw_s),
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .c(c8[2]), .busy(busy_v[2]));
  gf2m_mul_serial #(.M(8), .D(4), .POLY(9'h11B)) u3 (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_v[3]), .a(a_s[7:0]), .b(b_s[7:0]), .raw(raw_s),
    .out_valid(out_valid_v[3]), .out_ready(out_ready), .c(c8[3]), .busy(busy_v[3]));
  gf2m_mul_serial #(.M(8), .D(8), .POLY(9'h11B)) u4 (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_v[4]), .a(a_s[7:0]), .b(b_s[7:0]), .raw(raw_s),
    .out_valid(out_valid_v[4]), .out_ready(out_ready), .c(c8[4]), .busy(busy_v[4]));
  gf2m_mul_serial #(.M(16), .D(4), .POLY(17'h1002B)) u5 (.clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready_v[5]), .a(a_s), .b(b_s), .raw(raw_s),
    .out_valid(out_valid_v[5]), .out_ready(out_ready), .c(c16), .busy(busy_v[5]));

  function automatic logic [30:0] c_of(input int i);
    return (i < 5) ? 31'(c8[i]) : c16;
  endfunction

  // Bit-serial schoolbook multiply followed by long division, independent of digit size.
  function automatic logic [30:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic r, input int m, input logic [16:0] poly);
    logic [30:0] p;
    logic [15:0] msk;
    p   = '0;
    msk = 16'((32'd1 << m) - 1);
    for (int j = 0; j < m; j++)
      if (y[j]) p = p ^ (31'(x & msk) << j);
    if (!r)
      for (int i = 2 * m - 2; i >= m; i--)
        if (p[i]) p = p ^ (31'(poly) << (i - m));
    return p;
  endfunction

  task automatic check(input string name, input logic [30:0] act, input logic [30:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s got %0h required %0h", name, act, req);
  endtask

  // Score any handshake about to happen, then advance one clock and sample.
  task automatic step();
    for (int i = 0; i < 6; i++)
      if (rst_n && out_valid_v[i] && out_ready && !clear) begin
        if (exp_q[i].size() == 0) begin
          n_total++;
          $display("FAIL unexpected_out u%0d got %0h required none", i, c_of(i));
        end else
          check($sformatf("result_u%0d", i), c_of(i), exp_q[i].pop_front());
      end
    @(posedge clk);
    #1;
    edges++;
    for (int i = 0; i < 6; i++)
      if (out_valid_v[i] && !seen[i]) begin
        seen[i] = 1'b1;
        lat[i]  = edges;
      end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (in_ready_v != 6'h3F && t < 100) begin
      step();
      t++;
    end
    if (in_ready_v != 6'h3F) begin
      n_total++;
      $display("FAIL wait_idle got in_ready %b required 111111", in_ready_v);
    end
  endtask

  task automatic push_model(input logic [15:0] x, input logic [15:0] y, input logic r);
    for (int i = 0; i < 6; i++) exp_q[i].push_back(model(x, y, r, m_v[i], p_v[i]));
  endtask

  task automatic accept(input logic [15:0] x, input logic [15:0] y, input logic r);
    wait_idle();
    a_s = x; b_s = y; raw_s = r; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) seen[i] = 1'b0;
    step();
    edges    = 0;
    in_valid = 1'b0;
  endtask

  task automatic finish_txn(input bit check_lat);
    int t = 0;
    while (in_ready_v != 6'h3F && t < 60) begin
      step();
      t++;
    end
    if (in_ready_v != 6'h3F) begin
      n_total++;
      $display("FAIL finish_timeout got in_ready %b required 111111", in_ready_v);
    end
    if (check_lat)
      for (int i = 0; i < 6; i++)
        check($sformatf("latency_u%0d", i), seen[i] ? 31'(lat[i]) : 31'h0, 31'(n_v[i]));
  endtask

  initial begin
    tbl[0] = '{8'h57, 8'h83, 1'b0, 15'h00C1};
    tbl[1] = '{8'h57, 8'h83, 1'b1, 15'h2B79};
    tbl[2] = '{8'h57, 8'h13, 1'b0, 15'h00FE};
    tbl[3] = '{8'hA5, 8'h01, 1'b0, 15'h00A5};
    tbl[4] = '{8'hFF, 8'h00, 1'b0, 15'h0000};
    tbl[5] = '{8'hFF, 8'h00, 1'b1, 15'h0000};

    step(); step();
    check("rst_in_ready", 31'(in_ready_v), 31'h3F);
    check("rst_out_valid", 31'(out_valid_v), 31'h0);
    check("rst_busy", 31'(busy_v), 31'h0);
    check("rst_c_u0", c_of(0), 31'h0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 5; i++) exp_q[i].push_back(31'(tbl[v].exp));
      exp_q[5].push_back(model({8'h00, tbl[v].a}, {8'h00, tbl[v].b}, tbl[v].raw, 16, 17'h1002B));
      accept({8'h00, tbl[v].a}, {8'h00, tbl[v].b}, tbl[v].raw);
      finish_txn(1'b1);
    end

    // in_valid with different operands while busy must be ignored
    push_model(16'h0057, 16'h0083, 1'b0);
    accept(16'h0057, 16'h0083, 1'b0);
    a_s = 16'hFFFF; b_s = 16'hFFFF; raw_s = 1'b1; in_valid = 1'b1;
    step();
    check("in_ready_busy", 31'(in_ready_v[0]), 31'h0);
    check("busy_u0", 31'(busy_v[0]), 31'h1);
    in_valid = 1'b0;
    finish_txn(1'b1);

    // backpressure: result must hold for 10 cycles
    out_ready = 1'b0;
    push_model(16'h0057, 16'h0083, 1'b0);
    accept(16'h0057, 16'h0083, 1'b0);
    for (int t = 0; t < 20 && !out_valid_v[0]; t++) step();
    for (int t = 0; t < 10; t++) begin
      step();
      check("hold_out_valid", 31'(out_valid_v[0]), 31'h1);
      check("hold_c", c_of(0), 31'h00C1);
    end
    out_ready = 1'b1;
    finish_txn(1'b1);

    // clear one cycle into BUSY
    accept(16'h00FF, 16'h00FF, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_in_ready", 31'(in_ready_v[0]), 31'h1);
    check("clear_out_valid", 31'(out_valid_v[0]), 31'h0);
    check("clear_busy", 31'(busy_v[0]), 31'h0);
    check("clear_c_kept", c_of(0), 31'h00C1);
    for (int t = 0; t < 10; t++) step();
    check("clear_no_output", 31'(out_valid_v), 31'h0);

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    accept(16'h0012, 16'h0034, 1'b0);
    step(); step();
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 31'(in_ready_v), 31'h3F);
    check("arst_out_valid", 31'(out_valid_v), 31'h0);
    check("arst_busy", 31'(busy_v), 31'h0);
    check("arst_c_u0", c_of(0), 31'h0);
    check("arst_c_u5", c16, 31'h0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    for (int n = 0; n < 1000; n++) begin
      logic [15:0] x, y;
      logic r;
      x = 16'($urandom);
      y = 16'($urandom);
      r = 1'($urandom_range(0, 1));
      push_model(x, y, r);
      accept(x, y, r);
      finish_txn(1'b1);
    end

    for (int i = 0; i < 6; i++)
      check($sformatf("queue_empty_u%0d", i), 31'(exp_q[i].size()), 31'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
